// File: rtl/ddr_ahb_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the DDR CSR bank.
package ddr_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

endpackage

// File: rtl/ddr_ahb_byte_strobe.sv
// Byte-lane enables and size/alignment checks for one AHB address phase.
module ddr_ahb_byte_strobe
  import ddr_ahb_pkg::*;
#(
  parameter int NB = 4,
  parameter int LB = 2
) (
  input  logic [LB-1:0] addr,
  input  logic [2:0]    hsize,
  output logic [NB-1:0] strobe,
  output logic          misaligned,
  output logic          size_err
);

  always_comb begin
    strobe     = '0;
    misaligned = 1'b0;
    size_err   = (hsize > 3'(LB));
    for (int b = 0; b < NB; b++) begin
      if ((b >= int'(addr)) && (b < int'(addr) + (1 << hsize)))
        strobe[b] = 1'b1;
    end
    for (int i = 0; i < LB; i++) begin
      if ((i < int'(hsize)) && addr[i])
        misaligned = 1'b1;
    end
    // oversize transfers are rejected, so never let them enable lanes
    if (size_err)
      strobe = '0;
  end

endmodule

// File: rtl/ddr_ahb_csr_bank.sv
// AHB-Lite config/status register bank for DDR control, with wait states,
// byte strobes, two-cycle ERROR responses and per-register commit pulses.
//
// state   | meaning
// IDLE    | no stalled data phase; an OKAY phase with zero wait states completes here
// WAIT    | OKAY data phase stalled; completes when the down-counter reaches zero
// ERR1    | first ERROR cycle, hready low, address phases ignored
// ERR2    | second ERROR cycle, hready high, new transfer may be accepted
module ddr_ahb_csr_bank
  import ddr_ahb_pkg::*;
#(
  parameter int AWIDTH      = 32,
  parameter int DWIDTH      = 32,
  parameter int NUM_CFG     = 8,
  parameter int NUM_STA     = 4,
  parameter int WAIT_STATES = 0,
  parameter logic [NUM_CFG*DWIDTH-1:0] CFG_RESET_VAL = '0
) (
  input  logic                                      i_hclk,
  input  logic                                      i_hreset,
  input  logic [AWIDTH-1:0]                         i_haddr,
  input  logic                                      i_hwrite,
  input  logic                                      i_hsel,
  input  logic [DWIDTH-1:0]                         i_hwdata,
  input  logic [1:0]                                i_htrans,
  input  logic [2:0]                                i_hsize,
  input  logic [2:0]                                i_hburst,
  input  logic                                      i_hreadyin,
  output logic                                      o_hready,
  output logic [DWIDTH-1:0]                         o_hrdata,
  output logic [1:0]                                o_hresp,
  output logic [NUM_CFG*DWIDTH-1:0]                 o_cfg,
  output logic [NUM_CFG-1:0]                        o_cfg_wr_pulse,
  input  logic [((NUM_STA > 0) ? NUM_STA : 1)*DWIDTH-1:0] i_sta
);

  localparam int NB   = DWIDTH / 8;
  localparam int LB   = $clog2(NB);
  localparam int IDXW = AWIDTH - LB;
  localparam int NREG = NUM_CFG + NUM_STA;
  localparam int IW   = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int CW   = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  state_e            state_q, state_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic              ok_pend_q, ok_pend_n;
  logic              write_q;
  logic [IW-1:0]     idx_q;
  logic [NB-1:0]     strobe_q;
  logic [DWIDTH-1:0] cfg_q [NUM_CFG];
  logic [NUM_CFG-1:0] pulse_q;

  logic [IDXW-1:0]   a_idx;
  logic [NB-1:0]     lane_strobe;
  logic              misaligned, size_err, mapped, sta_wr, legal;
  logic              hready, accept, complete, commit;
  logic [DWIDTH-1:0] rd_word;
  logic              unused_bits;

  assign unused_bits = ^{i_hburst, i_htrans[0]};

  ddr_ahb_byte_strobe #(.NB(NB), .LB(LB)) u_strobe (
    .addr       (i_haddr[LB-1:0]),
    .hsize      (i_hsize),
    .strobe     (lane_strobe),
    .misaligned (misaligned),
    .size_err   (size_err)
  );

  assign a_idx  = i_haddr[AWIDTH-1:LB];
  assign mapped = (a_idx < IDXW'(NREG));
  assign sta_wr = i_hwrite && (a_idx >= IDXW'(NUM_CFG));
  assign legal  = mapped && !sta_wr && !size_err && !misaligned;

  assign hready = (state_q == ST_ERR1) ? 1'b0 :
                  (state_q == ST_WAIT) ? (cnt_q == '0) : 1'b1;
  assign accept   = i_hsel && i_htrans[1] && i_hreadyin && hready;
  assign complete = ok_pend_q && hready;
  assign commit   = complete && write_q;

  always_ff @(posedge i_hclk) begin
    if (!i_hreset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ok_pend_q <= 1'b0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      strobe_q  <= '0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      ok_pend_q <= ok_pend_n;
      if (accept) begin
        write_q  <= i_hwrite;
        idx_q    <= a_idx[IW-1:0];
        strobe_q <= lane_strobe;
      end
    end
  end

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    ok_pend_n = ok_pend_q;
    case (state_q)
      ST_IDLE: state_n = ST_IDLE;
      ST_WAIT: begin
        if (cnt_q != '0) cnt_n = cnt_q - 1'b1;
        else             state_n = ST_IDLE;
      end
      ST_ERR1: state_n = ST_ERR2;
      ST_ERR2: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (complete)
      ok_pend_n = 1'b0;
    // a new address phase overrides whatever the finishing phase chose
    if (accept) begin
      if (!legal) begin
        state_n   = ST_ERR1;
        ok_pend_n = 1'b0;
      end else begin
        ok_pend_n = 1'b1;
        if (WAIT_STATES > 0) begin
          state_n = ST_WAIT;
          cnt_n   = CW'(WAIT_STATES);
        end else begin
          state_n = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge i_hclk) begin
    if (!i_hreset) begin
      for (int k = 0; k < NUM_CFG; k++)
        cfg_q[k] <= CFG_RESET_VAL[k*DWIDTH +: DWIDTH];
      pulse_q <= '0;
    end else begin
      pulse_q <= '0;
      if (commit) begin
        for (int k = 0; k < NUM_CFG; k++) begin
          if (idx_q == IW'(k)) begin
            pulse_q[k] <= 1'b1;
            for (int b = 0; b < NB; b++)
              if (strobe_q[b]) cfg_q[k][b*8 +: 8] <= i_hwdata[b*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_CFG; k++)
      if (idx_q == IW'(k)) rd_word = cfg_q[k];
    for (int k = 0; k < NUM_STA; k++)
      if (idx_q == IW'(NUM_CFG + k)) rd_word = i_sta[k*DWIDTH +: DWIDTH];
  end

  for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg_out
    assign o_cfg[k*DWIDTH +: DWIDTH] = cfg_q[k];
  end

  assign o_hready       = hready;
  assign o_hresp        = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign o_hrdata       = (complete && !write_q) ? rd_word : '0;
  assign o_cfg_wr_pulse = pulse_q;

endmodule

// File: tb/tb_ddr_ahb_csr_bank.sv
// Directed bench: one bank with two wait states, one with none, sharing the bus.
module tb_ddr_ahb_csr_bank;

  localparam logic [255:0] RST_VAL = {192'h0, 32'h11223344, 32'h000000A5};
  localparam logic [127:0] STA_VAL = {32'h44440004, 32'h33330003, 32'h22220002, 32'h11110001};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] haddr;
  logic        hwrite;
  logic        hsel;
  logic        dsel;
  logic [31:0] hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [127:0] sta;

  logic        hsel_a, hsel_b;
  logic        hready_a, hready_b;
  logic [31:0] hrdata_a, hrdata_b;
  logic [1:0]  hresp_a, hresp_b;
  logic [255:0] cfg_a, cfg_b;
  logic [7:0]  pulse_a, pulse_b;

  logic        hready_m;
  logic [31:0] hrdata_m;
  logic [1:0]  hresp_m;

  int checks = 0;
  int errors = 0;
  logic [255:0] exp_a;

  logic [31:0] err_addr [4] = '{32'h20, 32'h30, 32'h1, 32'h0};
  logic        err_wr   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [2:0]  err_size [4] = '{3'd2, 3'd2, 3'd1, 3'd3};

  assign hsel_a   = hsel && !dsel;
  assign hsel_b   = hsel && dsel;
  assign hready_m = dsel ? hready_b : hready_a;
  assign hrdata_m = dsel ? hrdata_b : hrdata_a;
  assign hresp_m  = dsel ? hresp_b  : hresp_a;

  always #5 clk = ~clk;

  ddr_ahb_csr_bank #(
    .AWIDTH(32), .DWIDTH(32), .NUM_CFG(8), .NUM_STA(4), .WAIT_STATES(2), .CFG_RESET_VAL(RST_VAL)
  ) u_ws2 (
    .i_hclk(clk), .i_hreset(rst_n), .i_haddr(haddr), .i_hwrite(hwrite), .i_hsel(hsel_a),
    .i_hwdata(hwdata), .i_htrans(htrans), .i_hsize(hsize), .i_hburst(hburst),
    .i_hreadyin(hready_a), .o_hready(hready_a), .o_hrdata(hrdata_a), .o_hresp(hresp_a),
    .o_cfg(cfg_a), .o_cfg_wr_pulse(pulse_a), .i_sta(sta)
  );

  ddr_ahb_csr_bank #(
    .AWIDTH(32), .DWIDTH(32), .NUM_CFG(8), .NUM_STA(4), .WAIT_STATES(0), .CFG_RESET_VAL(RST_VAL)
  ) u_ws0 (
    .i_hclk(clk), .i_hreset(rst_n), .i_haddr(haddr), .i_hwrite(hwrite), .i_hsel(hsel_b),
    .i_hwdata(hwdata), .i_htrans(htrans), .i_hsize(hsize), .i_hburst(hburst),
    .i_hreadyin(hready_b), .o_hready(hready_b), .o_hrdata(hrdata_b), .o_hresp(hresp_b),
    .o_cfg(cfg_b), .o_cfg_wr_pulse(pulse_b), .i_sta(sta)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single transfer; returns one cycle after the completing edge.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata, output int lowc,
                      output logic [1:0] resp_first, output logic [1:0] resp_last);
    bit done;
    bit first;
    haddr = addr; hwrite = wr; hsize = size; htrans = 2'b10; hsel = 1'b1;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
    lowc = 0; done = 1'b0; first = 1'b1;
    rdata = '0; resp_first = '0; resp_last = '0;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clk);
      if (first) begin resp_first = hresp_m; first = 1'b0; end
      if (hready_m) begin
        rdata = hrdata_m; resp_last = hresp_m; done = 1'b1;
      end else begin
        lowc++;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $error("FAIL xfer_timeout addr=%0h observed=no_hready expected=hready", addr);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          lc;
    logic [1:0]  rf, rl;

    rst_n = 1'b0; haddr = '0; hwrite = 1'b0; hsel = 1'b0; dsel = 1'b0;
    hwdata = '0; htrans = 2'b00; hsize = 3'd2; hburst = 3'd0; sta = STA_VAL;
    exp_a = RST_VAL;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;

    @(negedge clk);
    chk("rst_reg0", {224'h0, cfg_a[31:0]}, 256'hA5);
    chk("rst_cfg", cfg_a, RST_VAL);
    chk("rst_hready", {255'h0, hready_a}, 256'h1);
    chk("rst_hresp", {254'h0, hresp_a}, 256'h0);
    chk("rst_hrdata", {224'h0, hrdata_a}, 256'h0);
    chk("rst_pulse", {248'h0, pulse_a}, 256'h0);
    @(posedge clk); #1;

    xfer(32'hC, 1'b1, 3'd2, 32'hDEADBEEF, rd, lc, rf, rl);
    exp_a[3*32 +: 32] = 32'hDEADBEEF;
    chk("wr3_lowc", lc, 2);
    chk("wr3_resp", {rf, rl}, 4'h0);
    chk("wr3_pulse", {248'h0, pulse_a}, 256'h08);
    chk("wr3_cfg", cfg_a, exp_a);
    @(posedge clk); #1;
    chk("wr3_pulse_gone", {248'h0, pulse_a}, 256'h0);

    xfer(32'hC, 1'b0, 3'd2, 32'h0, rd, lc, rf, rl);
    chk("rd3_data", rd, 32'hDEADBEEF);
    chk("rd3_lowc", lc, 2);
    chk("rd3_pulse", {248'h0, pulse_a}, 256'h0);

    xfer(32'h6, 1'b1, 3'd0, 32'h005A0000, rd, lc, rf, rl);
    exp_a[1*32 +: 32] = 32'h115A3344;
    chk("byte_reg1", {224'h0, cfg_a[63:32]}, 256'h115A3344);
    chk("byte_pulse", {248'h0, pulse_a}, 256'h02);

    xfer(32'hE, 1'b1, 3'd1, 32'hABCD0000, rd, lc, rf, rl);
    exp_a[3*32 +: 32] = 32'hABCDBEEF;
    chk("half_cfg", cfg_a, exp_a);
    chk("half_pulse", {248'h0, pulse_a}, 256'h08);

    xfer(32'h24, 1'b0, 3'd2, 32'h0, rd, lc, rf, rl);
    chk("sta1_data", rd, 32'h22220002);
    chk("sta1_resp", rl, 2'b00);

    for (int i = 0; i < 4; i++) begin
      xfer(err_addr[i], err_wr[i], err_size[i], 32'hFFFFFFFF, rd, lc, rf, rl);
      chk($sformatf("err%0d_lowc", i), lc, 1);
      chk($sformatf("err%0d_resp1", i), rf, 2'b01);
      chk($sformatf("err%0d_resp2", i), rl, 2'b01);
      chk($sformatf("err%0d_rdata", i), rd, 32'h0);
      chk($sformatf("err%0d_pulse", i), {248'h0, pulse_a}, 256'h0);
      chk($sformatf("err%0d_cfg", i), cfg_a, exp_a);
    end

    // zero-wait bank: write idx0, BUSY, then SEQ read of idx0
    dsel = 1'b1;
    haddr = 32'h0; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10; hsel = 1'b1;
    @(posedge clk); #1;
    hwdata = 32'h1; htrans = 2'b01;
    @(negedge clk);
    chk("b2b_wr_hready", {255'h0, hready_b}, 256'h1);
    @(posedge clk); #1;
    htrans = 2'b11; hwrite = 1'b0; haddr = 32'h0;
    @(negedge clk);
    chk("b2b_pulse", {248'h0, pulse_b}, 256'h01);
    chk("b2b_busy_rdata", {224'h0, hrdata_b}, 256'h0);
    chk("b2b_reg0", {224'h0, cfg_b[31:0]}, 256'h1);
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge clk);
    chk("b2b_rd_data", {224'h0, hrdata_b}, 256'h1);
    chk("b2b_rd_hready", {255'h0, hready_b}, 256'h1);
    chk("b2b_rd_pulse", {248'h0, pulse_b}, 256'h0);
    @(posedge clk); #1;

    // reset during the wait states of a write
    dsel = 1'b0;
    haddr = 32'h8; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10; hsel = 1'b1;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h12345678;
    @(negedge clk);
    chk("rstw_in_wait", {255'h0, hready_a}, 256'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_a = RST_VAL;
    @(negedge clk);
    chk("rstw_hready", {255'h0, hready_a}, 256'h1);
    chk("rstw_hresp", {254'h0, hresp_a}, 256'h0);
    chk("rstw_hrdata", {224'h0, hrdata_a}, 256'h0);
    chk("rstw_cfg", cfg_a, exp_a);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rstw_no_commit", cfg_a, exp_a);
    chk("rstw_pulse", {248'h0, pulse_a}, 256'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
